// File: rtl/wb_s_pkg_hdl.sv
// Shared types and default sizes for the Wishbone slave responder.
// Holds the FSM state encoding used by the responder.
package wb_s_pkg_hdl;

  localparam int WB_AW_DEF     = 32;
  localparam int WB_DW_DEF     = 16;
  localparam int MEM_DEPTH_DEF = 16;
  localparam int WAIT_DEF      = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_s_mem.sv
// Byte-lane writable word store for the responder.
// Async-reset array with a combinational read port.
module wb_s_mem
  import wb_s_pkg_hdl::*;
#(
  parameter int DW    = WB_DW_DEF,
  parameter int DEPTH = MEM_DEPTH_DEF,
  localparam int IW   = $clog2(DEPTH),
  localparam int NB   = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [NB-1:0] sel_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_s_responder.sv
// Wishbone classic slave: captures a request, waits, then acks or errs.
// Writes land on the edge that enters RESP; reads are registered into dat_o.
module wb_s_responder
  import wb_s_pkg_hdl::*;
#(
  parameter int WB_ADDR_WIDTH = WB_AW_DEF,
  parameter int WB_DATA_WIDTH = WB_DW_DEF,
  parameter int MEM_DEPTH     = MEM_DEPTH_DEF,
  parameter int WAIT_STATES   = WAIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [WB_ADDR_WIDTH-1:0]   adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   dat_i,
  input  logic [WB_DATA_WIDTH/8-1:0] sel_i,
  output logic [WB_DATA_WIDTH-1:0]   dat_o,
  output logic                       ack_o,
  output logic                       err_o,
  output logic [15:0]                xfer_count_o
);

  localparam int AW    = WB_ADDR_WIDTH;
  localparam int DW    = WB_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IW    = $clog2(MEM_DEPTH);
  localparam int SHIFT = OFF + IW;
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_e     state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [DW-1:0] wdat_q;
  logic [NB-1:0] sel_q;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          req;
  logic          enter;
  logic          in_rng;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [NB-1:0] m_sel;
  logic [IW-1:0] m_idx;
  logic          mem_we;
  logic [DW-1:0] mem_rd;

  assign req = cyc_i & stb_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wcnt_d  = WS_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With no wait states RESP is entered straight from IDLE,
  // so the live bus fields stand in for the captured ones.
  always_comb begin
    m_we   = we_q;
    m_adr  = adr_q;
    m_dat  = wdat_q;
    m_sel  = sel_q;
    if (state_q == ST_IDLE) begin
      m_we  = we_i;
      m_adr = adr_i;
      m_dat = dat_i;
      m_sel = sel_i;
    end
    m_idx  = m_adr[OFF +: IW];
    in_rng = ((m_adr >> SHIFT) == '0);
    enter  = (state_d == ST_RESP);
    mem_we = enter & m_we & in_rng;
    ack_d  = enter & in_rng;
    err_d  = enter & ~in_rng;
    rdat_d = (enter & in_rng & ~m_we) ? mem_rd : '0;
    cnt_d  = enter ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
      sel_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rdat_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && req) begin
        we_q   <= we_i;
        adr_q  <= adr_i;
        wdat_q <= dat_i;
        sel_q  <= sel_i;
      end
      ack_q  <= ack_d;
      err_q  <= err_d;
      rdat_q <= rdat_d;
      cnt_q  <= cnt_d;
    end
  end

  wb_s_mem #(
    .DW    (DW),
    .DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (m_idx),
    .wdata_i (m_dat),
    .sel_i   (m_sel),
    .raddr_i (m_idx),
    .rdata_o (mem_rd)
  );

  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign dat_o        = rdat_q;
  assign xfer_count_o = cnt_q;

endmodule

// File: tb/tb_wb_s_responder.sv
// Directed bench: one instance with one wait state, one with none.
// Table of single transfers plus abort, back-to-back and reset sequences.
module tb_wb_s_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cyc0 = 0, stb0 = 0, we0 = 0;
  logic [31:0] adr0 = '0;
  logic [15:0] dati0 = '0;
  logic [1:0]  sel0 = '0;
  logic [15:0] dato0;
  logic        ack0, err0;
  logic [15:0] cnt0;

  logic        cyc1 = 0, stb1 = 0, we1 = 0;
  logic [31:0] adr1 = '0;
  logic [15:0] dati1 = '0;
  logic [1:0]  sel1 = '0;
  logic [15:0] dato1;
  logic        ack1, err1;
  logic [15:0] cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_s_responder #(.WAIT_STATES(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .cyc_i(cyc0), .stb_i(stb0), .we_i(we0),
    .adr_i(adr0), .dat_i(dati0), .sel_i(sel0),
    .dat_o(dato0), .ack_o(ack0), .err_o(err0),
    .xfer_count_o(cnt0)
  );

  wb_s_responder #(.WAIT_STATES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .cyc_i(cyc1), .stb_i(stb1), .we_i(we1),
    .adr_i(adr1), .dat_i(dati1), .sel_i(sel1),
    .dat_o(dato1), .ack_o(ack1), .err_o(err1),
    .xfer_count_o(cnt1)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        ack;
    logic        err;
    logic [15:0] rd;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One transfer on the one-wait-state instance; cyc/stb held until ack.
  task automatic xfer0(input vec_t v, input int idx,
                       input logic [15:0] exp_cnt);
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    cyc0 = 1; stb0 = 1; we0 = v.we;
    adr0 = v.adr; dati0 = v.dat; sel0 = v.sel;
    @(posedge clk); #1;
    chk({nm, "_wait_ack"}, 32'(ack0), 32'(1'b0));
    chk({nm, "_wait_err"}, 32'(err0), 32'(1'b0));
    @(posedge clk); #1;
    chk({nm, "_ack"}, 32'(ack0), 32'(v.ack));
    chk({nm, "_err"}, 32'(err0), 32'(v.err));
    if (!v.we) chk({nm, "_dat"}, 32'(dato0), 32'(v.rd));
    chk({nm, "_cnt"}, 32'(cnt0), 32'(exp_cnt));
    @(negedge clk);
    cyc0 = 0; stb0 = 0; we0 = 0;
    @(posedge clk); #1;
    chk({nm, "_ack_end"}, 32'(ack0), 32'(1'b0));
    chk({nm, "_err_end"}, 32'(err0), 32'(1'b0));
    chk({nm, "_dat_end"}, 32'(dato0), 32'h0);
  endtask

  initial begin
    vec_t v;
    logic [15:0] ec;
    vt[0]  = '{1, 32'h0004, 16'hA5C3, 2'b11, 1, 0, 16'h0000};
    vt[1]  = '{0, 32'h0004, 16'h0000, 2'b11, 1, 0, 16'hA5C3};
    vt[2]  = '{1, 32'h0000, 16'h1234, 2'b11, 1, 0, 16'h0000};
    vt[3]  = '{1, 32'h0000, 16'hFF00, 2'b10, 1, 0, 16'h0000};
    vt[4]  = '{0, 32'h0000, 16'h0000, 2'b00, 1, 0, 16'hFF34};
    vt[5]  = '{0, 32'h0020, 16'h0000, 2'b11, 0, 1, 16'h0000};
    vt[6]  = '{1, 32'h0006, 16'h1111, 2'b00, 1, 0, 16'h0000};
    vt[7]  = '{0, 32'h0006, 16'h0000, 2'b11, 1, 0, 16'h0000};
    vt[8]  = '{1, 32'h001E, 16'h7777, 2'b01, 1, 0, 16'h0000};
    vt[9]  = '{0, 32'h001E, 16'h0000, 2'b11, 1, 0, 16'h0077};
    vt[10] = '{0, 32'h10000, 16'h0000, 2'b11, 0, 1, 16'h0000};
    vt[11] = '{1, 32'h10000, 16'hFFFF, 2'b11, 0, 1, 16'h0000};
    vt[12] = '{0, 32'h0000, 16'h0000, 2'b11, 1, 0, 16'hFF34};
    vt[13] = '{0, 32'h001F, 16'h0000, 2'b11, 1, 0, 16'h0077};

    #2;
    chk("rst_ack0", 32'(ack0), 32'h0);
    chk("rst_err0", 32'(err0), 32'h0);
    chk("rst_dat0", 32'(dato0), 32'h0);
    chk("rst_cnt0", 32'(cnt0), 32'h0);
    chk("rst_cnt1", 32'(cnt1), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 14; i++) begin
      ec = 16'(i + 1);
      xfer0(vt[i], i, ec);
    end

    // Abort a write by dropping cyc during the wait state.
    @(negedge clk);
    cyc0 = 1; stb0 = 1; we0 = 1;
    adr0 = 32'h0002; dati0 = 16'hBEEF; sel0 = 2'b11;
    @(posedge clk); #1;
    chk("abort_ack0", 32'(ack0), 32'h0);
    @(negedge clk);
    cyc0 = 0; stb0 = 0; we0 = 0;
    @(posedge clk); #1;
    chk("abort_ack1", 32'(ack0), 32'h0);
    chk("abort_err1", 32'(err0), 32'h0);
    @(posedge clk); #1;
    chk("abort_ack2", 32'(ack0), 32'h0);
    chk("abort_err2", 32'(err0), 32'h0);
    chk("abort_cnt", 32'(cnt0), 32'd14);
    v = '{0, 32'h0002, 16'h0, 2'b11, 1, 0, 16'h0000};
    xfer0(v, 100, 16'd15);

    // Zero wait states: write, then three back-to-back reads.
    @(negedge clk);
    cyc1 = 1; stb1 = 1; we1 = 1;
    adr1 = 32'h0002; dati1 = 16'hCAFE; sel1 = 2'b11;
    @(posedge clk); #1;
    chk("b2b_wr_ack", 32'(ack1), 32'h1);
    @(negedge clk);
    we1 = 0; dati1 = '0;
    @(posedge clk); #1;
    chk("b2b_gap0", 32'(ack1), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ack%0d", k), 32'(ack1), 32'h1);
      chk($sformatf("b2b_dat%0d", k), 32'(dato1), 32'hCAFE);
      chk($sformatf("b2b_err%0d", k), 32'(err1), 32'h0);
      if (k == 2) begin
        @(negedge clk);
        cyc1 = 0; stb1 = 0;
      end
      @(posedge clk); #1;
      chk($sformatf("b2b_idle%0d", k), 32'(ack1), 32'h0);
      chk($sformatf("b2b_idat%0d", k), 32'(dato1), 32'h0);
    end
    chk("b2b_cnt", 32'(cnt1), 32'd4);

    // Reset in the wait state of a write.
    @(negedge clk);
    cyc0 = 1; stb0 = 1; we0 = 1;
    adr0 = 32'h0008; dati0 = 16'h5555; sel0 = 2'b11;
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("rstw_ack", 32'(ack0), 32'h0);
    chk("rstw_err", 32'(err0), 32'h0);
    chk("rstw_dat", 32'(dato0), 32'h0);
    chk("rstw_cnt", 32'(cnt0), 32'h0);
    chk("rstw_cnt1", 32'(cnt1), 32'h0);
    @(negedge clk);
    cyc0 = 0; stb0 = 0; we0 = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    chk("rstw_post_ack", 32'(ack0), 32'h0);
    v = '{0, 32'h0008, 16'h0, 2'b11, 1, 0, 16'h0000};
    xfer0(v, 200, 16'd1);
    v = '{0, 32'h0004, 16'h0, 2'b11, 1, 0, 16'h0000};
    xfer0(v, 201, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
